// File: rtl/golden_nonce_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : golden_nonce_uart_tx_if
//  Brief    : Nonce delivery link from the hashing core to the UART transmitter
//  Revision : 1.0
// ============================================================================
interface golden_nonce_uart_tx_if;
    logic [31:0] nonce_in;
    logic        nonce_valid;
    logic        fifo_full;

    modport master (output nonce_in, output nonce_valid, input  fifo_full);
    modport slave  (input  nonce_in, input  nonce_valid, output fifo_full);
endinterface
`default_nettype wire

// File: rtl/golden_nonce_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : golden_nonce_uart_tx
//  Brief    : Buffers golden nonces and sends each as 4 little-endian 8N1 bytes
//  Revision : 1.0
// ============================================================================
module golden_nonce_uart_tx #(
    parameter int CLK_HZ          = 130000000,
    parameter int BAUD            = 115200,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    golden_nonce_uart_tx_if.slave        nonce_if,
    output logic                         TxD,
    output logic                         busy,
    output logic [7:0]                   drop_cnt
);

    localparam int BIT_CLKS   = CLK_HZ / BAUD;
    localparam int c_TMR_W    = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
    localparam int c_CNT_W    = FIFO_DEPTH_LOG2 + 1;
    localparam int c_DEPTH_N  = 1 << FIFO_DEPTH_LOG2;
    localparam logic [c_TMR_W-1:0] c_TMR_RELOAD = c_TMR_W'(BIT_CLKS - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH      = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

    generate
        if (BIT_CLKS < 2) begin : g_bad_bit_clks
            $error("golden_nonce_uart_tx: CLK_HZ/BAUD must be at least 2");
        end
        if (FIFO_DEPTH_LOG2 < 1) begin : g_bad_fifo_depth
            $error("golden_nonce_uart_tx: FIFO_DEPTH_LOG2 must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               r_state, w_state_next;
    logic [c_TMR_W-1:0]   r_timer, w_timer_next;
    logic [2:0]           r_bit_idx, w_bit_idx_next;
    logic [1:0]           r_byte_idx, w_byte_idx_next;
    logic [31:0]          r_shift, w_shift_next;
    logic                 r_txd, w_txd_next;
    logic                 w_tick;
    logic                 w_cur_bit;

    logic [31:0]                r_mem [c_DEPTH_N];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0]         r_count, w_count_next;
    logic                       r_fifo_full;
    logic [7:0]                 r_drop_cnt;
    logic                       w_empty, w_full_now;
    logic                       w_pop, w_push, w_drop;

    // ------------------------------------------------------------------
    // Nonce FIFO
    // ------------------------------------------------------------------
    assign w_empty      = (r_count == '0);
    assign w_full_now   = (r_count == c_DEPTH);
    // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
    assign w_push       = nonce_if.nonce_valid && (!w_full_now || w_pop);
    assign w_drop       = nonce_if.nonce_valid && w_full_now && !w_pop;
    assign w_count_next = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= nonce_if.nonce_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_fifo_full <= 1'b0;
            r_drop_cnt  <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count     <= w_count_next;
            r_fifo_full <= (w_count_next == c_DEPTH);
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    assign w_tick    = (r_timer == '0);
    assign w_cur_bit = r_shift[{r_byte_idx, r_bit_idx}];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 2'd0;
            r_shift    <= 32'd0;
            r_txd      <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_timer    <= w_timer_next;
            r_bit_idx  <= w_bit_idx_next;
            r_byte_idx <= w_byte_idx_next;
            r_shift    <= w_shift_next;
            r_txd      <= w_txd_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_timer_next    = r_timer;
        w_bit_idx_next  = r_bit_idx;
        w_byte_idx_next = r_byte_idx;
        w_shift_next    = r_shift;
        w_pop           = 1'b0;
        w_txd_next      = 1'b1;

        // Every non-idle level runs the timer; any transition reloads it.
        if (r_state != S_IDLE) begin
            w_timer_next = w_tick ? c_TMR_RELOAD : (r_timer - 1'b1);
        end

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop           = 1'b1;
                    w_shift_next    = r_mem[r_rd_ptr];
                    w_byte_idx_next = 2'd0;
                    w_bit_idx_next  = 3'd0;
                    w_timer_next    = c_TMR_RELOAD;
                    w_state_next    = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_bit_idx_next = 3'd0;
                    w_state_next   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_byte_idx != 2'd3) begin
                        w_byte_idx_next = r_byte_idx + 2'd1;
                        w_state_next    = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Pin level follows the current state one clock later, so it stays glitch-free.
        case (r_state)
            S_START: w_txd_next = 1'b0;
            S_DATA:  w_txd_next = w_cur_bit;
            default: w_txd_next = 1'b1;
        endcase
    end

    assign TxD                = r_txd;
    assign busy               = (r_state != S_IDLE) || !w_empty;
    assign drop_cnt           = r_drop_cnt;
    assign nonce_if.fifo_full = r_fifo_full;

endmodule
`default_nettype wire

// File: tb/tb_golden_nonce_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_golden_nonce_uart_tx
//  Brief    : Scoreboard bench: queue reference model plus UART decoding monitor
//  Revision : 1.0
// ============================================================================
module tb_golden_nonce_uart_tx;

    localparam int CLK_HZ = 16;
    localparam int BAUD   = 1;
    localparam int LOG2   = 2;
    localparam int DEPTH  = 4;
    localparam int FRAME  = 4 * 10 * (CLK_HZ / BAUD);

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic       TxD;
    logic       busy;
    logic [7:0] drop_cnt;

    golden_nonce_uart_tx_if nif();

    golden_nonce_uart_tx #(
        .CLK_HZ          (CLK_HZ),
        .BAUD            (BAUD),
        .FIFO_DEPTH_LOG2 (LOG2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .nonce_if (nif),
        .TxD      (TxD),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: FIFO contents, transmitter busy time and drop counter.
    logic [31:0] mq[$];
    logic [31:0] expq[$];
    int          m_tx   = 0;
    int          m_drop = 0;
    bit          m_pop;
    bit          m_was_full;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            expq.delete();
            m_tx   = 0;
            m_drop = 0;
        end else begin
            m_was_full = (mq.size() == DEPTH);
            m_pop      = (m_tx == 0) && (mq.size() != 0);
            if (m_pop) begin
                expq.push_back(mq.pop_front());
                m_tx = FRAME;
            end else if (m_tx > 0) begin
                m_tx--;
            end
            if (nif.nonce_valid) begin
                if (!m_was_full || m_pop) mq.push_back(nif.nonce_in);
                else if (m_drop < 255)    m_drop++;
            end
        end
    end

    // Monitor: mid-bit UART receiver assembling 4-byte frames.
    bit          rx_active = 0;
    int          rx_cnt    = 0;
    int          rx_nbyte  = 0;
    logic [7:0]  rx_byte;
    logic [31:0] rx_word;
    int          byte_start;
    int          frame_start;
    int          fs_q[$];
    int          frames_seen = 0;
    int          low_seen    = 0;

    always @(negedge clk) begin
        if (TxD !== 1'b1) low_seen++;
        if (!reset_n) begin
            rx_active = 0;
            rx_nbyte  = 0;
        end else if (!rx_active) begin
            if (TxD === 1'b0) begin
                if (rx_nbyte > 0) chk("byte_spacing", 32'(cyc - byte_start), 32'd160);
                else              frame_start = cyc;
                byte_start = cyc;
                rx_active  = 1;
                rx_cnt     = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % 16 == 8) begin
                if (rx_cnt == 8) begin
                    chk("start_bit", 32'(TxD), 32'd0);
                end else if (rx_cnt < 152) begin
                    rx_byte[rx_cnt / 16 - 1] = TxD;
                end else begin
                    chk("stop_bit", 32'(TxD), 32'd1);
                    rx_active = 0;
                    rx_word[8 * rx_nbyte +: 8] = rx_byte;
                    rx_nbyte++;
                    if (rx_nbyte == 4) begin
                        rx_nbyte = 0;
                        frames_seen++;
                        fs_q.push_back(frame_start);
                        if (expq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame: got %0h expected none", rx_word);
                        end else begin
                            chk("frame_data", rx_word, expq.pop_front());
                        end
                    end
                end
            end
        end
    end

    // Per-cycle status comparison against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("fifo_full", 32'(nif.fifo_full), (mq.size() == DEPTH) ? 32'd1 : 32'd0);
            chk("busy", 32'(busy), ((m_tx != 0) || (mq.size() != 0)) ? 32'd1 : 32'd0);
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        end
    end

    task automatic push(input logic [31:0] v);
        nif.nonce_in    = v;
        nif.nonce_valid = 1'b1;
        @(negedge clk);
        nif.nonce_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((m_tx != 0 || mq.size() != 0 || expq.size() != 0 || rx_active) && n < 8000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", (n >= 8000) ? 32'd1 : 32'd0, 32'd0);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    int c0;
    int n;
    int fr0;
    logic [7:0] saved_drop;

    initial begin
        nif.nonce_in    = 32'd0;
        nif.nonce_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("reset_txd", 32'(TxD), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_fifo_full", 32'(nif.fifo_full), 32'd0);
        chk("reset_drop_cnt", 32'(drop_cnt), 32'd0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);

        // 1: single nonce, start-bit latency
        fs_q.delete();
        c0 = cyc;
        push(32'h195a2c52);
        drain();
        chk("frame_count_t1", 32'(fs_q.size()), 32'd1);
        if (fs_q.size() > 0) chk("latency", 32'(fs_q[0]), 32'(c0 + 3));

        // 2: two back-to-back nonces, one idle clock between frames
        fs_q.delete();
        push(32'h00000000);
        push(32'hffffffff);
        drain();
        chk("frame_count_t2", 32'(fs_q.size()), 32'd2);
        if (fs_q.size() == 2) chk("frame_gap", 32'(fs_q[1] - fs_q[0]), 32'(FRAME + 1));

        // 3: six strobes, one dropped
        for (int i = 0; i < 6; i++) push($urandom);
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("t3_fifo_full", 32'(nif.fifo_full), 32'd1);
        fr0 = frames_seen;
        drain();
        chk("t3_frames", 32'(frames_seen - fr0), 32'd5);

        // 4: drop counter saturation
        for (int i = 0; i < 5; i++) push($urandom);
        for (int i = 0; i < 300; i++) push($urandom);
        chk("t4_drop_sat", 32'(drop_cnt), 32'd255);
        drain();

        // 5: reset during byte 2, bit 3
        push(32'h12345678);
        repeat (394) @(negedge clk);
        chk("t5_pre_reset_txd", 32'(TxD), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_reset_txd", 32'(TxD), 32'd1);
        chk("t5_reset_drop", 32'(drop_cnt), 32'd0);
        chk("t5_reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        fr0      = frames_seen;
        low_seen = 0;
        repeat (700) @(negedge clk);
        chk("t5_quiet_low", 32'(low_seen), 32'd0);
        chk("t5_quiet_frames", 32'(frames_seen - fr0), 32'd0);

        // 6: push on a full FIFO in the cycle IDLE pops
        fr0 = frames_seen;
        for (int i = 0; i < 5; i++) push($urandom);
        n = 0;
        while (!(m_tx == 0 && mq.size() == DEPTH) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_wait_timeout", (n >= 2000) ? 32'd1 : 32'd0, 32'd0);
        saved_drop = drop_cnt;
        push($urandom);
        chk("t6_drop_same", 32'(drop_cnt), 32'(saved_drop));
        chk("t6_fifo_full", 32'(nif.fifo_full), 32'd1);
        drain();
        chk("t6_frames", 32'(frames_seen - fr0), 32'd6);

        // 7: random traffic with occasional bursts
        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 600)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(3, 7)) push($urandom);
            end else begin
                push($urandom);
            end
        end
        drain();
        chk("t7_idle_txd", 32'(TxD), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
